mult_div_unit: RTL and testbench

Iterative HI/LO multiply/divide unit for the MIPS execute stage. It sits directly downstream of the register file: `rs` comes from read port 1 and `rt` from read port 2. It executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the 64-bit result in architectural HI/LO registers. It also services MTHI/MTLO writes and provides HI/LO for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit for the execute stage.
//   One shift-add (multiply) or restoring shift-subtract (divide) step per
//   cycle, WIDTH steps per operation, then one cycle of sign fix-up that
//   writes HI/LO and pulses done.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   start       begin op (sampled in IDLE only)
//   op          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a   rs: multiplicand / dividend
//   operand_b   rt: multiplier / divisor
//   hi_we/lo_we MTHI/MTLO write strobes (IDLE only, start has priority)
//   write_data  MTHI/MTLO data
//   busy        operation in progress (registered)
//   done        one-cycle pulse when HI/LO take a result (registered)
//   hi/lo       architectural HI/LO
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

    state_t             r_state, w_next_state;
    logic [CW-1:0]      r_count;
    logic               r_busy, r_done;
    logic [WIDTH-1:0]   r_hi, r_lo;

    // Working state: r_work holds {acc, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide. r_opnd is the addend
    // (multiplicand magnitude) or the divisor magnitude.
    logic [2*WIDTH-1:0] r_work;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_raw;
    logic               r_is_div, r_neg_q, r_neg_r, r_div_zero;

    // Start-cycle operand decode. op[0]=0 selects the signed variants.
    logic               w_a_neg, w_b_neg, w_is_div;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;

    assign w_is_div = op[1];
    assign w_a_neg  = ~op[0] & operand_a[WIDTH-1];
    assign w_b_neg  = ~op[0] & operand_b[WIDTH-1];
    assign w_mag_a  = w_a_neg ? -operand_a : operand_a;
    assign w_mag_b  = w_b_neg ? -operand_b : operand_b;

    // One iteration step for each algorithm.
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_sub;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_mul_sum   = {1'b0, r_work[2*WIDTH-1:WIDTH]}
                       + (r_work[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next  = {w_mul_sum, r_work[WIDTH-1:1]};

    // Remainder stays below the divisor, so the shifted value needs one
    // extra bit for the compare but the difference fits in WIDTH bits.
    assign w_rem_shift = {r_work[2*WIDTH-1:WIDTH], r_work[WIDTH-1]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_opnd});
    assign w_rem_sub   = w_rem_shift[WIDTH-1:0] - r_opnd;
    assign w_div_next  = {(w_ge ? w_rem_sub : w_rem_shift[WIDTH-1:0]),
                          r_work[WIDTH-2:0], w_ge};

    // Final sign correction. Divide by zero bypasses the datapath result:
    // quotient all ones, remainder is the raw dividend.
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
    logic [2*WIDTH-1:0] w_result;

    assign w_prod_fix = r_neg_q ? -r_work : r_work;
    assign w_quo_fix  = r_neg_q ? -r_work[WIDTH-1:0] : r_work[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -r_work[2*WIDTH-1:WIDTH] : r_work[2*WIDTH-1:WIDTH];

    always_comb begin
        w_result = w_prod_fix;
        if (r_is_div) begin
            if (r_div_zero) w_result = {r_a_raw, {WIDTH{1'b1}}};
            else            w_result = {w_rem_fix, w_quo_fix};
        end
    end

    // FSM
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_CALC;
            S_CALC:   if (r_count == CW'(WIDTH - 1)) w_next_state = S_FINISH;
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Datapath and architectural registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_work     <= '0;
            r_opnd     <= '0;
            r_a_raw    <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_count    <= '0;
                        r_is_div   <= w_is_div;
                        r_a_raw    <= operand_a;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= (operand_b == '0);
                        r_opnd     <= w_is_div ? w_mag_b : w_mag_a;
                        r_work     <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                    end else begin
                        if (hi_we) r_hi <= write_data;
                        if (lo_we) r_lo <= write_data;
                    end
                end
                S_CALC: begin
                    r_work  <= r_is_div ? w_div_next : w_mul_next;
                    r_count <= r_count + 1'b1;
                end
                S_FINISH: begin
                    {r_hi, r_lo} <= w_result;
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    localparam int W = 32;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  operand_a, operand_b, write_data;
    logic          hi_we, lo_we;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2*W-1:0] sb[$];

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
    } vec_t;

    vec_t vecs[14];

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .hi_we(hi_we), .lo_we(lo_we), .write_data(write_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Runs one operation from IDLE. Expected {hi,lo} goes to the scoreboard
    // at start and is popped when done appears. poke>=0 drives junk
    // start/hi_we/lo_we for one cycle, sampled at edge E(poke+1).
    task automatic run_op(input string nm, input logic [1:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input logic with_we,
                          input int poke);
        logic [W-1:0] h0, l0;
        logic held, got;
        logic [2*W-1:0] e;
        int lat;
        @(negedge clk);
        h0 = hi; l0 = lo;
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        hi_we = with_we; lo_we = with_we; write_data = 32'h0000_1234;
        sb.push_back(exp);
        @(posedge clk); @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        operand_a = $urandom; operand_b = $urandom;
        chk({nm, " busy_after_start"}, 64'(busy), 64'd1);
        held = 1'b1; got = 1'b0; lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == poke + 1) begin start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; end
            if (done) begin got = 1'b1; lat = k; break; end
            if (!busy || hi !== h0 || lo !== l0) held = 1'b0;
            if (k == poke) begin
                start = 1'b1; op = MULTU; operand_a = $urandom; operand_b = $urandom;
                hi_we = 1'b1; lo_we = 1'b1; write_data = 32'hDEAD_BEEF;
            end
        end
        chk({nm, " busy_and_hilo_held"}, 64'(held), 64'd1);
        if (!got) begin
            chk({nm, " done_timeout"}, 64'(got), 64'd1);
            void'(sb.pop_front());
        end else begin
            chk({nm, " latency"}, 64'(lat), 64'(W + 1));
            chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
            if (sb.size() == 0) begin
                chk({nm, " scoreboard_empty"}, 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk({nm, " hilo"}, {hi, lo}, e);
            end
        end
        @(posedge clk); @(negedge clk);
        chk({nm, " done_one_cycle"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [2*W-1:0] rexp;

        vecs[0]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        vecs[4]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{DIVU,  32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 32'h0000_0003};
        vecs[6]  = '{MULT,  32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
        vecs[7]  = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[9]  = '{MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[10] = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[11] = '{DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[12] = '{DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};
        vecs[13] = '{MULTU, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};

        rst = 1'b0; start = 1'b0; op = MULTU; operand_a = '0; operand_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; write_data = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy_done", {62'd0, busy, done}, 64'd0);
        rst = 1'b1;

        // MTHI + MTLO together in IDLE
        hi_we = 1'b1; lo_we = 1'b1; write_data = 32'h0000_1234;
        @(posedge clk); @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthi_mtlo", {hi, lo}, {32'h0000_1234, 32'h0000_1234});

        // start beats a simultaneous write
        run_op("start_wins", MULTU, 32'd2, 32'd3, {32'd0, 32'd6}, 1'b1, -1);

        // MTHI alone leaves LO untouched
        @(negedge clk);
        hi_we = 1'b1; write_data = 32'hA5A5_A5A5;
        @(posedge clk); @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_only", {hi, lo}, {32'hA5A5_A5A5, 32'd6});

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   {vecs[i].hi, vecs[i].lo}, 1'b0, -1);

        // start/hi_we while busy, and during the FINISH edge: both ignored
        run_op("poke_busy",   DIVU, 32'd10, 32'd3, {32'd1, 32'd3}, 1'b0, 4);
        run_op("poke_finish", DIVU, 32'd10, 32'd3, {32'd1, 32'd3}, 1'b0, W);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom;
            rexp = {32'd0, ra} * {32'd0, rb};
            run_op($sformatf("rnd_multu%0d", i), MULTU, ra, rb, rexp, 1'b0, -1);
            rb = $urandom_range(32'hFFFF, 1);
            rexp = {ra % rb, ra / rb};
            run_op($sformatf("rnd_divu%0d", i), DIVU, ra, rb, rexp, 1'b0, -1);
        end

        // Reset in the middle of a multiply abandons it
        @(negedge clk);
        op = MULTU; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midop_reset hilo", {hi, lo}, 64'd0);
        chk("midop_reset busy_done", {62'd0, busy, done}, 64'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset idle", {62'd0, busy, done}, 64'd0);
        run_op("after_reset", MULTU, 32'd7, 32'd6, {32'd0, 32'd42}, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
